mul_fu: RTL

RV32M multiply functional unit: accepts MUL/MULH/MULHSU/MULHU ops from the multiply reservation station, drives the iterative `shift_add_multiplier` through its start/done handshake, selects the low or high result half, and holds the result until the common data bus (CDB) arbiter grants it. It sits between issue and CDB. It handles one operation at a time and discards in-flight work on pipeline flush.

---
 rtl/rv32_pkg.sv | 47 ++++
 rtl/shift_add_multiplier.sv | 103 ++++++++++
 rtl/mul_fu.sv | 136 +++++++++++++
 3 files changed

// File: rtl/rv32_pkg.sv
// Shared RV32 definitions used by the execution units.
// Contents:
//   FUNCT3_*   M-extension funct3 codes for the multiply group
//   MUL_*      operand signedness encodings understood by shift_add_multiplier
//   mul_dec_t  decoded multiply op (multiplier type + which product half)
//   decode_funct3  funct3 -> mul_dec_t
package rv32_pkg;

  localparam logic [2:0] FUNCT3_MUL    = 3'b000;
  localparam logic [2:0] FUNCT3_MULH   = 3'b001;
  localparam logic [2:0] FUNCT3_MULHSU = 3'b010;
  localparam logic [2:0] FUNCT3_MULHU  = 3'b011;

  localparam logic [1:0] MUL_UU = 2'b00;
  localparam logic [1:0] MUL_SS = 2'b01;
  localparam logic [1:0] MUL_SU = 2'b10;

  typedef struct packed {
    logic [1:0] mul_type;
    logic       hi_sel;
  } mul_dec_t;

  // MUL runs as unsigned: the low half of the product does not depend on
  // operand signedness, so no correction term is needed.
  function automatic mul_dec_t decode_funct3(input logic [2:0] funct3);
    mul_dec_t dec;
    dec.mul_type = MUL_UU;
    dec.hi_sel   = 1'b0;
    case (funct3)
      FUNCT3_MULH: begin
        dec.mul_type = MUL_SS;
        dec.hi_sel   = 1'b1;
      end
      FUNCT3_MULHSU: begin
        dec.mul_type = MUL_SU;
        dec.hi_sel   = 1'b1;
      end
      FUNCT3_MULHU: begin
        dec.mul_type = MUL_UU;
        dec.hi_sel   = 1'b1;
      end
      default: ;
    endcase
    return dec;
  endfunction

endpackage

// File: rtl/shift_add_multiplier.sv
// Iterative shift-and-add multiplier.
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   start_i        sampled in IDLE to begin; held low in DONE to release
//   a_i, b_i       operands, must stay stable until done_o
//   mul_type_i     MUL_UU / MUL_SS / MUL_SU signedness of (a, b)
//   done_o         high while the product is available
//   p_o            full 2*OPERAND_WIDTH product (combinational in mul_type_i)
// Latency: start sampled at cycle t gives done_o at t + 2*OPERAND_WIDTH + 1.
module shift_add_multiplier
  import rv32_pkg::*;
#(
  parameter int OPERAND_WIDTH = 32
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         start_i,
  input  logic [OPERAND_WIDTH-1:0]     a_i,
  input  logic [OPERAND_WIDTH-1:0]     b_i,
  input  logic [1:0]                   mul_type_i,
  output logic                         done_o,
  output logic [2*OPERAND_WIDTH-1:0]   p_o
);

  localparam int W  = OPERAND_WIDTH;
  localparam int CW = $clog2(2 * W);

  typedef enum logic [1:0] {M_IDLE, M_RUN, M_DONE} mstate_e;

  mstate_e        state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2*W-1:0] acc_q, acc_d;
  logic [2*W-1:0] mcand_q, mcand_d;
  logic [W-1:0]   mplier_q, mplier_d;
  logic [2*W-1:0] corrA, corrB;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= M_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
    end
  end

  // Each multiplier bit takes two cycles: an even cycle conditionally adds
  // the shifted multiplicand, the following odd cycle shifts.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    case (state_q)
      M_IDLE: begin
        if (start_i) begin
          state_d  = M_RUN;
          cnt_d    = '0;
          acc_d    = '0;
          mcand_d  = {{W{1'b0}}, a_i};
          mplier_d = b_i;
        end
      end
      M_RUN: begin
        if (!cnt_q[0]) begin
          if (mplier_q[0]) acc_d = acc_q + mcand_q;
        end else begin
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(2 * W - 1)) state_d = M_DONE;
      end
      M_DONE: begin
        if (!start_i) state_d = M_IDLE;
      end
      default: state_d = M_IDLE;
    endcase
  end

  // The accumulator holds the unsigned product; a negative operand in two's
  // complement is worth its unsigned value minus 2^W, so subtract the other
  // operand shifted by W for each operand treated as signed.
  always_comb begin
    corrA = '0;
    corrB = '0;
    if (a_i[W-1] && (mul_type_i == MUL_SS || mul_type_i == MUL_SU))
      corrA = {b_i, {W{1'b0}}};
    if (b_i[W-1] && mul_type_i == MUL_SS)
      corrB = {a_i, {W{1'b0}}};
  end

  assign p_o    = acc_q - corrA - corrB;
  assign done_o = (state_q == M_DONE);

endmodule

// File: rtl/mul_fu.sv
// RV32M multiply functional unit: accepts one MUL/MULH/MULHSU/MULHU op at a
// time, runs it on the iterative multiplier and holds the result for the CDB.
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   flush_i             squash the current op; nothing is broadcast for it
//   issue_valid_i/_ready_o, issue_funct3_i, issue_rs1_i, issue_rs2_i,
//   issue_tag_i         issue handshake and operands from the reservation station
//   cdb_req_o, cdb_grant_i, cdb_tag_o, cdb_data_o
//                       result request / grant to the CDB arbiter
module mul_fu
  import rv32_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int ROB_IDX_W = 5
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 flush_i,
  input  logic                 issue_valid_i,
  output logic                 issue_ready_o,
  input  logic [2:0]           issue_funct3_i,
  input  logic [XLEN-1:0]      issue_rs1_i,
  input  logic [XLEN-1:0]      issue_rs2_i,
  input  logic [ROB_IDX_W-1:0] issue_tag_i,
  output logic                 cdb_req_o,
  input  logic                 cdb_grant_i,
  output logic [ROB_IDX_W-1:0] cdb_tag_o,
  output logic [XLEN-1:0]      cdb_data_o
);

  typedef enum logic [1:0] {IDLE, BUSY, RESULT, DRAIN} fu_state_e;

  fu_state_e              state_q, state_d;
  logic [XLEN-1:0]        rs1_q, rs1_d, rs2_q, rs2_d;
  logic [ROB_IDX_W-1:0]   tag_q, tag_d;
  logic [1:0]             type_q, type_d;
  logic                   hi_q, hi_d;
  logic                   start_q, start_d;
  logic [XLEN-1:0]        data_q, data_d;
  logic [ROB_IDX_W-1:0]   cdb_tag_q, cdb_tag_d;

  logic                   accept;
  logic                   mulDone;
  logic [2*XLEN-1:0]      mulProd;
  mul_dec_t               dec;

  assign dec           = decode_funct3(issue_funct3_i);
  assign issue_ready_o = (state_q == IDLE) && !flush_i;
  assign accept        = issue_valid_i && issue_ready_o;
  assign cdb_req_o     = (state_q == RESULT);
  assign cdb_tag_o     = cdb_tag_q;
  assign cdb_data_o    = data_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      rs1_q     <= '0;
      rs2_q     <= '0;
      tag_q     <= '0;
      type_q    <= MUL_UU;
      hi_q      <= 1'b0;
      start_q   <= 1'b0;
      data_q    <= '0;
      cdb_tag_q <= '0;
    end else begin
      state_q   <= state_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      tag_q     <= tag_d;
      type_q    <= type_d;
      hi_q      <= hi_d;
      start_q   <= start_d;
      data_q    <= data_d;
      cdb_tag_q <= cdb_tag_d;
    end
  end

  // DRAIN leaves on done even if flush is still asserted: the multiplier
  // shows done for only one cycle once start is low, so waiting for flush
  // to drop as well could strand the unit.
  always_comb begin
    state_d   = state_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    tag_d     = tag_q;
    type_d    = type_q;
    hi_d      = hi_q;
    data_d    = data_q;
    cdb_tag_d = cdb_tag_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          rs1_d   = issue_rs1_i;
          rs2_d   = issue_rs2_i;
          tag_d   = issue_tag_i;
          type_d  = dec.mul_type;
          hi_d    = dec.hi_sel;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (flush_i) begin
          state_d = DRAIN;
        end else if (mulDone) begin
          data_d    = hi_q ? mulProd[2*XLEN-1:XLEN] : mulProd[XLEN-1:0];
          cdb_tag_d = tag_q;
          state_d   = RESULT;
        end
      end
      RESULT: begin
        if (flush_i || cdb_grant_i) state_d = IDLE;
      end
      DRAIN: begin
        if (mulDone) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Registering start off the next state makes it rise together with BUSY
    // and fall the cycle after done, releasing the multiplier back to IDLE.
    start_d = (state_d == BUSY);
  end

  shift_add_multiplier #(
    .OPERAND_WIDTH(XLEN)
  ) u_mult (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .start_i    (start_q),
    .a_i        (rs1_q),
    .b_i        (rs2_q),
    .mul_type_i (type_q),
    .done_o     (mulDone),
    .p_o        (mulProd)
  );

endmodule
